// File: rtl/load_ext_pipe.sv
// load_ext_pipe: load-data byte/half/word/full extraction with sign/zero extension, registered valid/ready with skid.
// Optional LOAD_EXT_ADEL_CNT_EN adds a saturating count of accepted misaligned accesses.
module load_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_adel
`ifdef LOAD_EXT_ADEL_CNT_EN
    ,output logic [15:0]      adel_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t r_state, w_next;
    logic              r_in_ready, r_out_adel, r_skid_adel, w_adel;
    logic              w_in_x, w_out_x, w_load_out, w_load_skid, w_from_skid;
    logic [DATA_W-1:0] r_out_data, r_skid_data, w_shift, w_field, w_res;
    assign w_in_x    = in_valid & r_in_ready;
    assign w_out_x   = out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_state != EMPTY;
    assign out_data  = r_out_data;
    assign out_adel  = r_out_adel;
    // Aligned accesses only ever use the low bits of the offset-shifted word, so one shifter serves every size.
    assign w_shift = in_data >> {in_off, 3'b000};
    always_comb begin
        w_adel  = (in_size == 2'd1 && in_off[0]) || (in_size == 2'd2 && in_off[1:0] != 2'b00) ||
                  (in_size == 2'd3 && in_off != '0);
        w_field = in_size == 2'd0 ? (in_unsigned ? DATA_W'(w_shift[7:0])  : DATA_W'($signed(w_shift[7:0]))) :
                  in_size == 2'd1 ? (in_unsigned ? DATA_W'(w_shift[15:0]) : DATA_W'($signed(w_shift[15:0]))) :
                  in_size == 2'd2 ? (in_unsigned ? DATA_W'(w_shift[31:0]) : DATA_W'($signed(w_shift[31:0]))) :
                  w_shift;
        w_res   = w_adel ? '0 : w_field;
    end
    always_comb begin
        w_next      = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                w_next     = w_in_x ? ONE : EMPTY;
                w_load_out = w_in_x;
            end
            ONE: begin
                w_next      = w_in_x ? (w_out_x ? ONE : TWO) : (w_out_x ? EMPTY : ONE);
                w_load_out  = w_in_x & w_out_x;
                w_load_skid = w_in_x & ~w_out_x;
            end
            TWO: begin
                w_next      = w_out_x ? ONE : TWO;
                w_from_skid = w_out_x;
            end
            default: w_next = EMPTY;
        endcase
        if (flush) begin
            w_next      = EMPTY;
            w_load_out  = 1'b0;
            w_load_skid = 1'b0;
            w_from_skid = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_data  <= '0;
            r_out_adel  <= 1'b0;
            r_skid_data <= '0;
            r_skid_adel <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= w_next != TWO;
            if (flush) begin
                r_out_adel <= 1'b0;
            end else if (w_load_out) begin
                r_out_data <= w_res;
                r_out_adel <= w_adel;
            end else if (w_from_skid) begin
                r_out_data <= r_skid_data;
                r_out_adel <= r_skid_adel;
            end
            if (w_load_skid) begin
                r_skid_data <= w_res;
                r_skid_adel <= w_adel;
            end
        end
    end
`ifdef LOAD_EXT_ADEL_CNT_EN
    logic [15:0] r_adel_cnt;
    assign adel_cnt = r_adel_cnt;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_adel_cnt <= '0;
        else if (w_in_x && w_adel && r_adel_cnt != 16'hFFFF)
            r_adel_cnt <= r_adel_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_load_ext_pipe.sv
// tb_load_ext_pipe: scoreboard bench driving a 32-bit and a 64-bit instance of load_ext_pipe.
module tb_load_ext_pipe;
    localparam logic [64:0] ADEL = {1'b1, 64'h0};
    logic        clk = 0, resetn = 0, flush = 0, v32 = 0, v64 = 0, rdy32 = 0, rdy64 = 0, uns = 0;
    logic [63:0] din = '0;
    logic [2:0]  off = '0;
    logic [1:0]  sz = '0;
    logic        ir32, ov32, oa32, ir64, ov64, oa64;
    logic [31:0] od32;
    logic [63:0] od64;
    logic [64:0] q32[$], q64[$];
    int          checks = 0, failures = 0;
`ifdef LOAD_EXT_ADEL_CNT_EN
    logic [15:0] cnt32, cnt64;
`endif
    always #5 clk = ~clk;

    load_ext_pipe #(.DATA_W(32)) u_d32 (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(v32), .in_ready(ir32),
        .in_data(din[31:0]), .in_off(off[1:0]), .in_size(sz), .in_unsigned(uns),
        .out_valid(ov32), .out_ready(rdy32), .out_data(od32), .out_adel(oa32)
`ifdef LOAD_EXT_ADEL_CNT_EN
        , .adel_cnt(cnt32)
`endif
    );
    load_ext_pipe #(.DATA_W(64)) u_d64 (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(v64), .in_ready(ir64),
        .in_data(din), .in_off(off), .in_size(sz), .in_unsigned(uns),
        .out_valid(ov64), .out_ready(rdy64), .out_data(od64), .out_adel(oa64)
`ifdef LOAD_EXT_ADEL_CNT_EN
        , .adel_cnt(cnt64)
`endif
    );

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: gather bytes little-endian, then widen; alignment is offset modulo field size.
    function automatic logic [64:0] model(input logic [63:0] d, input logic [2:0] o, input logic [1:0] s,
                                          input logic u, input bit w64);
        int w, nb;
        logic [63:0] v;
        w  = w64 ? 64 : 32;
        nb = s == 0 ? 1 : s == 1 ? 2 : s == 2 ? 4 : w / 8;
        v  = '0;
        if (int'(o) % nb != 0) return ADEL;
        for (int i = 0; i < nb; i++) v = v | (((d >> (8 * (int'(o) + i))) & 64'hFF) << (8 * i));
        if (!u && s != 2'd3 && v[8*nb-1])
            for (int b = 8 * nb; b < w; b++) v[b] = 1'b1;
        return {1'b0, v};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        v32 = 0;
        v64 = 0;
    endtask

    task automatic send(input bit w64, input logic [63:0] d, input logic [2:0] o, input logic [1:0] s,
                        input logic u, input logic [64:0] e, input bit rnd);
        bit acc;
        acc = 0;
        din = d; off = o; sz = s; uns = u;
        v32 = !w64;
        v64 = w64;
        for (int i = 0; i < 64 && !acc; i++) begin
            if (rnd) begin
                if (w64) rdy64 = 1'($urandom);
                else     rdy32 = 1'($urandom);
            end
            if (w64 ? ir64 : ir32) begin
                if (w64) q64.push_back(e);
                else     q32.push_back(e);
                acc = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) check("accept_timeout", 65'(acc), 65'd1);
    endtask

    always @(negedge clk) begin
        if (resetn && ov32 && rdy32) begin
            if (q32.size() == 0) check("q32_extra", 65'(q32.size()), 65'd1);
            else check("out32", {oa32, 32'h0, od32}, q32.pop_front());
        end
        if (resetn && ov64 && rdy64) begin
            if (q64.size() == 0) check("q64_extra", 65'(q64.size()), 65'd1);
            else check("out64", {oa64, od64}, q64.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [2:0]  o;
        logic [1:0]  s;
        logic        u;
        #12;
        check("rst_ov", 65'(ov32), 65'd0);
        check("rst_od", 65'(od32), 65'd0);
        check("rst_oa", 65'(oa32), 65'd0);
        check("rst_ir", 65'(ir32), 65'd1);
        check("rst_ov64", 65'(ov64), 65'd0);
        @(negedge clk);
        resetn = 1;
        cyc(1);
        rdy32 = 1;
        rdy64 = 1;
        send(0, 64'h80FF7F01, 3'd2, 2'd0, 1'b0, 65'hFFFFFFFF, 0);
        check("lat32", 65'(ov32), 65'd1);
        send(0, 64'h80FF7F01, 3'd3, 2'd0, 1'b0, 65'hFFFFFF80, 0);
        send(0, 64'h80FF7F01, 3'd3, 2'd0, 1'b1, 65'h80, 0);
        send(0, 64'h80011234, 3'd2, 2'd1, 1'b0, 65'hFFFF8001, 0);
        send(0, 64'h80011234, 3'd0, 2'd3, 1'b1, 65'h80011234, 0);
        send(0, 64'h80011234, 3'd1, 2'd1, 1'b0, ADEL, 0);
        idle();
        cyc(2);
`ifdef LOAD_EXT_ADEL_CNT_EN
        check("adel_cnt", 65'(cnt32), 65'd1);
`endif
        send(0, 64'h80011234, 3'd2, 2'd2, 1'b0, ADEL, 0);
        send(0, 64'h80011234, 3'd2, 2'd3, 1'b0, ADEL, 0);
        send(1, 64'h80000000_12345678, 3'd4, 2'd2, 1'b0, 65'hFFFFFFFF_80000000, 0);
        send(1, 64'h80000000_12345678, 3'd4, 2'd2, 1'b1, 65'h00000000_80000000, 0);
        send(1, 64'h80000000_12345678, 3'd0, 2'd3, 1'b0, 65'h80000000_12345678, 0);
        send(1, 64'h80000000_12345678, 3'd4, 2'd3, 1'b0, ADEL, 0);
        send(1, 64'h80000000_12345678, 3'd7, 2'd0, 1'b0, 65'hFFFFFFFF_FFFFFF80, 0);
        send(1, 64'h80000000_12345678, 3'd6, 2'd1, 1'b1, 65'h8000, 0);
        idle();
        cyc(2);
        for (int i = 0; i < 40; i++) begin
            d = {32'h0, $urandom};
            o = 3'($urandom_range(0, 3));
            s = 2'($urandom);
            u = 1'($urandom);
            send(0, d, o, s, u, model(d, o, s, u, 0), 1);
        end
        for (int i = 0; i < 40; i++) begin
            d = {$urandom, $urandom};
            o = 3'($urandom);
            s = 2'($urandom);
            u = 1'($urandom);
            send(1, d, o, s, u, model(d, o, s, u, 1), 1);
        end
        idle();
        rdy32 = 1;
        rdy64 = 1;
        cyc(4);
        check("drain32", 65'(q32.size()), 65'd0);
        check("drain64", 65'(q64.size()), 65'd0);
        rdy32 = 0;
        send(0, 64'h44332211, 3'd0, 2'd0, 1'b1, 65'h11, 0);
        send(0, 64'h44332211, 3'd1, 2'd0, 1'b1, 65'h22, 0);
        din = 64'h44332211; off = 3'd2; v32 = 1;
        check("bp_ready", 65'(ir32), 65'd0);
        check("bp_hold", {oa32, 32'h0, od32}, 65'h11);
        cyc(1);
        check("bp_stable", {oa32, 32'h0, od32}, 65'h11);
        rdy32 = 1;
        send(0, 64'h44332211, 3'd2, 2'd0, 1'b1, 65'h33, 0);
        send(0, 64'h44332211, 3'd3, 2'd0, 1'b1, 65'h44, 0);
        idle();
        cyc(3);
        check("bp_drain", 65'(q32.size()), 65'd0);
        rdy32 = 0;
        send(0, 64'h44332211, 3'd0, 2'd0, 1'b1, 65'h11, 0);
        send(0, 64'h44332211, 3'd1, 2'd0, 1'b1, 65'h22, 0);
        check("two_ready", 65'(ir32), 65'd0);
        din = 64'h44332211; off = 3'd2; v32 = 1; flush = 1;
        q32.delete();
        cyc(1);
        flush = 0;
        idle();
        check("flush_ov", 65'(ov32), 65'd0);
        check("flush_ir", 65'(ir32), 65'd1);
        check("flush_oa", 65'(oa32), 65'd0);
        rdy32 = 1;
        send(0, 64'h44332211, 3'd3, 2'd0, 1'b0, 65'h44, 0);
        check("flush_lat", 65'(ov32), 65'd1);
        idle();
        cyc(1);
        check("flush_alone", 65'(ov32), 65'd0);
        check("flush_q", 65'(q32.size()), 65'd0);
        rdy32 = 0;
        send(0, 64'h80FF7F01, 3'd1, 2'd1, 1'b0, ADEL, 0);
        idle();
        check("pre_rst_ov", 65'(ov32), 65'd1);
        #2;
        resetn = 0;
        #1;
        check("arst_ov", 65'(ov32), 65'd0);
        check("arst_od", 65'(od32), 65'd0);
        check("arst_ir", 65'(ir32), 65'd1);
        q32.delete();
        q64.delete();
        #3;
        resetn = 1;
        cyc(1);
        check("post_rst_ir", 65'(ir32), 65'd1);
        check("post_rst_ov", 65'(ov32), 65'd0);
`ifdef LOAD_EXT_ADEL_CNT_EN
        check("rst_cnt", 65'(cnt32), 65'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
